// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller: funct3 encodings,
// controller states and the access-width legality rule.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ST_RD,
        ST_WR,
        RESP
    } state_e;

    // Stores have no unsigned variants, so only B/H/W are valid for them.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data path: extracts and extends load data from a RAM word,
// and merges sub-word store data into a previously read word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rword_i,
    input  logic [31:0] old_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_data_o
);

    always_comb begin
        load_data_o = '0;
        case (funct3_i)
            F3_B:    load_data_o = {{24{rword_i[7]}}, rword_i[7:0]};
            F3_H:    load_data_o = {{16{rword_i[15]}}, rword_i[15:0]};
            F3_W:    load_data_o = rword_i;
            F3_BU:   load_data_o = {24'd0, rword_i[7:0]};
            F3_HU:   load_data_o = {16'd0, rword_i[15:0]};
            default: load_data_o = '0;
        endcase
    end

    // Full-word stores never read the old word, so they bypass the merge.
    always_comb begin
        store_data_o = wdata_i;
        case (funct3_i)
            F3_B:    store_data_o = {old_i[31:8], wdata_i[7:0]};
            F3_H:    store_data_o = {old_i[31:16], wdata_i[15:0]};
            default: store_data_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: accepts one request at a time, sequences the RAM's
// whole-word port (read, write or read-modify-write) and returns one response.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 64,
    parameter int unsigned PROT_BASE = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        ram_read_en,
    output logic        ram_write_en,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_write_data,
    input  logic [31:0] ram_read_data
);

    localparam logic [31:0] LowAddr  = 32'(PROT_BASE);
    localparam logic [31:0] HighAddr = 32'(MEM_BYTES - 4);

    state_e      state_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] old_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        req_legal;
    logic [31:0] load_data;
    logic [31:0] store_data;
    logic        ram_active;

    // The RAM always touches four bytes, hence the MEM_BYTES-4 upper bound.
    assign req_legal = (req_addr >= LowAddr) && (req_addr <= HighAddr) &&
                       f3_legal(req_we, req_funct3);

    lsu_align u_align (
        .funct3_i     (funct3_q),
        .rword_i      (ram_read_data),
        .old_i        (old_q),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data),
        .store_data_o (store_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            old_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        rdata_q  <= '0;
                        err_q    <= ~req_legal;
                        if (!req_legal) begin
                            state_q <= RESP;
                        end else if (!req_we) begin
                            state_q <= LOAD;
                        end else if (req_funct3 == F3_W) begin
                            state_q <= ST_WR;
                        end else begin
                            state_q <= ST_RD;
                        end
                    end
                end
                LOAD: begin
                    rdata_q <= load_data;
                    state_q <= RESP;
                end
                ST_RD: begin
                    old_q   <= ram_read_data;
                    state_q <= ST_WR;
                end
                ST_WR: begin
                    state_q <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Gating with rst guarantees a reset in ST_WR never commits a partial RMW.
    assign ram_active     = ((state_q == LOAD) || (state_q == ST_RD) ||
                             (state_q == ST_WR)) && !rst;
    assign ram_read_en    = ((state_q == LOAD) || (state_q == ST_RD)) && !rst;
    assign ram_write_en   = (state_q == ST_WR) && !rst;
    assign ram_addr       = ram_active ? addr_q : 32'd0;
    assign ram_write_data = ram_write_en ? store_data : 32'd0;

    assign req_ready  = (state_q == IDLE) && !rst;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    logic unused_we;
    assign unused_we = we_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus random requests
// compared against a byte-array reference model of the memory.
module tb_lsu_ctrl;

    localparam int MEM_BYTES = 64;
    localparam int PROT_BASE = 24;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        ram_read_en;
    logic        ram_write_en;
    logic [31:0] ram_addr;
    logic [31:0] ram_write_data;
    logic [31:0] ram_read_data;

    logic [7:0] mem    [MEM_BYTES];
    logic [7:0] refMem [MEM_BYTES];

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(
        .MEM_BYTES (MEM_BYTES),
        .PROT_BASE (PROT_BASE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .ram_read_en    (ram_read_en),
        .ram_write_en   (ram_write_en),
        .ram_addr       (ram_addr),
        .ram_write_data (ram_write_data),
        .ram_read_data  (ram_read_data)
    );

    // Little-endian combinational RAM read port
    always_comb begin
        ram_read_data = '0;
        if (ram_addr <= 32'(MEM_BYTES - 4)) begin
            for (int k = 0; k < 4; k++) begin
                ram_read_data[8*k +: 8] = mem[int'(ram_addr) + k];
            end
        end
    end

    always @(posedge clk) begin
        if (ram_write_en && ram_addr <= 32'(MEM_BYTES - 4)) begin
            for (int k = 0; k < 4; k++) begin
                mem[int'(ram_addr) + k] <= ram_write_data[8*k +: 8];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one request; updates refMem for legal stores
    task automatic modelRequest(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic expErr,
                                output logic [31:0] expData, output int expLat,
                                output int expReads, output int expWrites,
                                output logic [31:0] expWord);
        logic [31:0] word;
        int nBytes;
        bit legal;
        legal = (addr >= 32'(PROT_BASE)) && (addr <= 32'(MEM_BYTES - 4));
        if (we) legal = legal && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        else    legal = legal && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        expErr    = !legal;
        expData   = '0;
        expReads  = 0;
        expWrites = 0;
        expWord   = '0;
        expLat    = 1;
        if (legal) begin
            word = '0;
            for (int k = 0; k < 4; k++) word[8*k +: 8] = refMem[int'(addr) + k];
            if (!we) begin
                expLat   = 2;
                expReads = 1;
                case (f3)
                    3'd0: expData = (word & 32'hFF) | (word[7] ? 32'hFFFFFF00 : 32'h0);
                    3'd1: expData = (word & 32'hFFFF) | (word[15] ? 32'hFFFF0000 : 32'h0);
                    3'd4: expData = word & 32'hFF;
                    3'd5: expData = word & 32'hFFFF;
                    default: expData = word;
                endcase
            end else begin
                nBytes    = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
                expWrites = 1;
                expReads  = (nBytes == 4) ? 0 : 1;
                expLat    = (nBytes == 4) ? 2 : 3;
                for (int k = 0; k < nBytes; k++) refMem[int'(addr) + k] = wdata[8*k +: 8];
                for (int k = 0; k < 4; k++) expWord[8*k +: 8] = refMem[int'(addr) + k];
            end
        end
    endtask

    // Issue one request at a negedge, follow it to its response and check it
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int holdCycles);
        logic        expErr;
        logic [31:0] expData;
        logic [31:0] expWord;
        logic [31:0] heldData;
        logic        heldErr;
        int expLat, expReads, expWrites;
        int cycle, reads, writes, wrCycle, n;
        modelRequest(we, f3, addr, wdata, expErr, expData, expLat, expReads, expWrites, expWord);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reqReady", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        cycle   = 1;
        reads   = 0;
        writes  = 0;
        wrCycle = -1;
        while (!resp_valid && cycle < 10) begin
            if (ram_read_en) begin
                reads++;
                checkOutput("readAddr", ram_addr, addr);
            end
            if (ram_write_en) begin
                writes++;
                wrCycle = cycle;
                checkOutput("writeAddr", ram_addr, addr);
                checkOutput("writeData", ram_write_data, expWord);
            end
            @(negedge clk);
            cycle++;
        end
        checkOutput("latency", 32'(cycle), 32'(expLat));
        checkOutput("reads", 32'(reads), 32'(expReads));
        checkOutput("writes", 32'(writes), 32'(expWrites));
        if (expWrites != 0) checkOutput("writeCycle", 32'(wrCycle), 32'(expLat - 1));
        checkOutput("respErr", {31'd0, resp_err}, {31'd0, expErr});
        checkOutput("respData", resp_rdata, expData);
        heldData = expData;
        heldErr  = expErr;
        for (int h = 0; h < holdCycles; h++) begin
            @(negedge clk);
            checkOutput("holdValid", {31'd0, resp_valid}, 32'd1);
            checkOutput("holdData", resp_rdata, heldData);
            checkOutput("holdErr", {31'd0, resp_err}, {31'd0, heldErr});
            checkOutput("holdReady", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        checkOutput("idleReady", {31'd0, req_ready}, 32'd1);
        checkOutput("idleValid", {31'd0, resp_valid}, 32'd0);
    endtask

    // Abort an SH with reset asserted during its write cycle
    task automatic resetDuringWrite(input logic [31:0] addr);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd1;
        req_addr   = addr;
        req_wdata  = 32'h0000CAFE;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("rmwRead", {31'd0, ram_read_en}, 32'd1);
        @(negedge clk);
        checkOutput("rmwWrite", {31'd0, ram_write_en}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rstGateWrite", {31'd0, ram_write_en}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rstIdleReady", {31'd0, req_ready}, 32'd1);
        checkOutput("rstNoResp", {31'd0, resp_valid}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            checkOutput("rstMemKept", {24'd0, mem[int'(addr) + k]}, {24'd0, refMem[int'(addr) + k]});
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'($urandom);
        mem[30] = 8'h80;
        mem[32] = 8'h44;
        mem[33] = 8'h33;
        mem[34] = 8'h22;
        mem[35] = 8'h11;
        for (int i = 0; i < MEM_BYTES; i++) refMem[i] = mem[i];

        @(posedge clk);
        @(negedge clk);
        checkOutput("rstReqReady", {31'd0, req_ready}, 32'd0);
        checkOutput("rstRespValid", {31'd0, resp_valid}, 32'd0);
        checkOutput("rstRdata", resp_rdata, 32'd0);
        checkOutput("rstErr", {31'd0, resp_err}, 32'd0);
        checkOutput("rstRamEn", {30'd0, ram_read_en, ram_write_en}, 32'd0);
        checkOutput("rstRamAddr", ram_addr, 32'd0);
        checkOutput("rstRamWdata", ram_write_data, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("postRstReady", {31'd0, req_ready}, 32'd1);
        @(negedge clk);

        applyStimulus(1'b0, 3'd0, 32'd30, 32'd0, 0);
        applyStimulus(1'b0, 3'd4, 32'd30, 32'd0, 0);
        applyStimulus(1'b1, 3'd0, 32'd32, 32'h000000AB, 0);
        applyStimulus(1'b0, 3'd2, 32'd32, 32'd0, 0);
        applyStimulus(1'b1, 3'd2, 32'd40, 32'hDEADBEEF, 0);
        applyStimulus(1'b0, 3'd1, 32'd42, 32'd0, 0);
        applyStimulus(1'b0, 3'd2, 32'd20, 32'd0, 0);
        applyStimulus(1'b1, 3'd2, 32'd61, 32'h12345678, 0);
        applyStimulus(1'b0, 3'd3, 32'd40, 32'd0, 0);
        applyStimulus(1'b1, 3'd4, 32'd40, 32'h55555555, 0);
        applyStimulus(1'b0, 3'd2, 32'd24, 32'd0, 0);
        applyStimulus(1'b0, 3'd2, 32'd60, 32'd0, 0);
        applyStimulus(1'b0, 3'd2, 32'd23, 32'd0, 0);
        resetDuringWrite(32'd44);
        @(negedge clk);
        applyStimulus(1'b0, 3'd2, 32'd40, 32'd0, 5);

        for (int t = 0; t < 80; t++) begin
            we   = 1'($urandom);
            addr = 32'($urandom_range(66, 16));
            if ($urandom_range(3, 0) != 0) begin
                if (we) f3 = 3'($urandom_range(2, 0));
                else    f3 = ($urandom_range(1, 0) != 0) ? 3'($urandom_range(2, 0))
                                                        : 3'($urandom_range(5, 4));
            end else begin
                f3 = 3'($urandom);
            end
            applyStimulus(we, f3, addr, $urandom, int'($urandom_range(3, 0)));
        end

        for (int i = 0; i < MEM_BYTES; i++) begin
            checkOutput("memFinal", {24'd0, mem[i]}, {24'd0, refMem[i]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller sitting between the core's memory stage and the byte-addressable data RAM. It accepts one RISC-V load or store per request handshake and sequences the RAM's whole-word port: read-then-extend for LB/LH/LW/LBU/LHU, direct write for SW, and read-modify-write for SB/SH. It also rejects accesses to the protected low region or past the end of memory and returns one response per request.

## Interface
Parameters:
- MEM_BYTES, 64: RAM size in bytes.
- PROT_BASE, 24: lowest legal byte address; addresses below it are protected.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, low bytes significant.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  access rejected.
- ram_read_en  out  1  to RAM read_en.
- ram_write_en  out  1  to RAM write_en.
- ram_addr  out  32  to RAM addr.
- ram_write_data  out  32  to RAM write_data.
- ram_read_data  in  32  from RAM; combinational, little-endian {addr+3..addr}.

## Operation
- States: IDLE, LOAD, ST_RD, ST_WR, RESP.
- IDLE: req_ready = 1. On req_valid, latch we, funct3, addr and wdata, then check legality.
- Illegal access goes to RESP with err = 1 and no RAM access. An access is illegal if any of these holds:
  - addr < PROT_BASE;
  - addr > MEM_BYTES-4 (the RAM always touches 4 bytes);
  - funct3 ∉ {000, 001, 010, 100, 101} for loads;
  - funct3 ∉ {000, 001, 010} for stores.
- Legal load goes to LOAD. ram_read_en = 1 and ram_addr = latched addr. Capture ram_read_data[7:0] or [15:0] or [31:0], sign-extend (B, H) or zero-extend (BU, HU), then go to RESP.
- Legal SW goes to ST_WR.
- Legal SB/SH goes to ST_RD: ram_read_en = 1 and capture the old word, then go to ST_WR.
- ST_WR: ram_write_en = 1.
  - ram_write_data = wdata for SW.
  - For SB: {old[31:8], wdata[7:0]}.
  - For SH: {old[31:16], wdata[15:0]}.
  - Then go to RESP.
- RESP: resp_valid = 1. Go to IDLE when resp_ready; otherwise hold resp_rdata and resp_err stable.
- Outside LOAD, ST_RD and ST_WR: ram_read_en = ram_write_en = 0, and ram_addr = ram_write_data = 0.
- No misalignment trap: unaligned legal addresses are passed through, because the RAM handles any byte offset.

## Timing
- Reset values: state IDLE; resp_valid 0; resp_rdata 0; resp_err 0; all ram_* outputs 0.
- req_ready = (state == IDLE) & ~rst, so it is 0 during the reset cycle.
- Cycle counts, with acceptance in cycle 0:
  - load: RAM read in cycle 1, resp_valid in cycle 2;
  - SW: RAM write at the end of cycle 1, resp_valid in cycle 2;
  - SB/SH: read in cycle 1, write at the end of cycle 2, resp_valid in cycle 3;
  - error: resp_valid in cycle 1.
- At most one outstanding request. No new acceptance before the response handshake completes, so the earliest next accept is the cycle after resp_valid & resp_ready.
- ram_write_en = (state == ST_WR) & ~rst. Reset asserted in an ST_WR cycle suppresses the write; no partial RMW is ever committed.
- Reset in any state aborts to IDLE next cycle and discards any pending response.
- All ram_* outputs are combinational from registered state/latches only, not from req_*.

## Structure
- Package lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the state enum.
- Sub-module lsu_align is purely combinational. It provides:
  - load extract/extend (funct3, word → rdata);
  - store merge (funct3, old, wdata → new word).
- The FSM and latches live in lsu_ctrl.

## Test plan
- RAM byte 30 = 0x80. LB addr 30 → resp_rdata 0xFFFFFF80, err 0, resp_valid 2 cycles after accept. LBU addr 30 → 0x00000080.
- Word at 32 = 0x11223344. SB addr 32, wdata 0xAB → one read, then a write of 0x112233AB. Response arrives in cycle 3. A following LW addr 32 returns 0x112233AB.
- SW addr 40, wdata 0xDEADBEEF → no read cycle; ram_write_en in cycle 1 only. LH addr 42 → 0xFFFFDEAD.
- LW addr 20 and SW addr 61 → resp_err 1 in cycle 1. ram_read_en/ram_write_en never asserted; RAM contents unchanged.
- Load with funct3 011 and store with funct3 100 → both return err 1.
- Reset asserted in the ST_WR cycle of an SH → no write (RAM unchanged); controller in IDLE next cycle. Separately, resp_ready held low 5 cycles → resp_valid and resp_rdata held stable and req_ready held 0.
